hwpe_sel_ctrl: RTL and testbench

Runtime HWPE selection controller for the cluster HWPE subsystem. It replaces static, instantaneous select muxing with a safe switch sequence: drain outstanding TCDM and config traffic, gate the old HWPE clock, enable the new one, let it settle, then re-open traffic. It drives the select, per-HWPE clock enables, and req/gnt gating; the static TCDM/config data muxes downstream consume `sel_o`.

---
 rtl/hwpe_sel_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_hwpe_sel_ctrl.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hwpe_sel_ctrl.sv
// hwpe_sel_ctrl
// Runtime HWPE selection controller. A select change is sequenced so no
// traffic is lost: drain TCDM and config traffic of the active HWPE, gate its
// clock for one cycle while the select moves, let the new HWPE settle, then
// re-open traffic. Downstream data muxes consume sel_o.
//
// Ports
//   clk, rst_n             clock, synchronous active-low reset
//   hwpe_en_i              global HWPE enable (qualifies clock enables)
//   sel_req_*              select request handshake (ready only in ACTIVE)
//   sel_o, switching_o     active index, high while a switch is in progress
//   hwpe_clk_en_o          per-HWPE clock-gate enable
//   hwpe_busy_i, busy_o    per-HWPE busy in, subsystem busy out
//   hwpe_evt_i, evt_o      per-HWPE event bundles in, active bundle out
//   hwpe_tcdm_req_i/gnt_o  per-HWPE TCDM request/grant
//   tcdm_req_o/gnt_i/r_valid_i  shared TCDM interconnect side
//   cfg_req_i, cfg_gnt_o   config bus side
//   periph_req_o/gnt_i/r_valid_i  per-HWPE config side
//
// state  | meaning
// ACTIVE | traffic open, switch requests accepted
// DRAIN  | traffic blocked, waiting for outstanding/config/busy to clear
// SWITCH | one cycle with all clocks gated; select updates at cycle end
// SETTLE | new HWPE clocked, traffic still blocked for SETTLE_CYCLES

module hwpe_sel_ctrl #(
  parameter int unsigned N_HWPES         = 4,
  parameter int unsigned LOG_N_HWPES     = (N_HWPES == 1) ? 1 : $clog2(N_HWPES),
  parameter int unsigned N_CORES         = 8,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned SETTLE_CYCLES   = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           hwpe_en_i,
  input  logic [LOG_N_HWPES-1:0]         sel_req_i,
  input  logic                           sel_req_valid_i,
  output logic                           sel_req_ready_o,
  output logic [LOG_N_HWPES-1:0]         sel_o,
  output logic                           switching_o,
  output logic [N_HWPES-1:0]             hwpe_clk_en_o,
  input  logic [N_HWPES-1:0]             hwpe_busy_i,
  input  logic [N_HWPES*N_CORES*2-1:0]   hwpe_evt_i,
  output logic [N_CORES*2-1:0]           evt_o,
  output logic                           busy_o,
  input  logic [N_HWPES-1:0]             hwpe_tcdm_req_i,
  output logic [N_HWPES-1:0]             hwpe_tcdm_gnt_o,
  output logic                           tcdm_req_o,
  input  logic                           tcdm_gnt_i,
  input  logic                           tcdm_r_valid_i,
  input  logic                           cfg_req_i,
  output logic                           cfg_gnt_o,
  output logic [N_HWPES-1:0]             periph_req_o,
  input  logic [N_HWPES-1:0]             periph_gnt_i,
  input  logic [N_HWPES-1:0]             periph_r_valid_i
);

  localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned SET_W = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES);
  localparam int unsigned EVT_W = 2 * N_CORES;
  localparam logic [OUT_W-1:0] MAX_OUT     = OUT_W'(MAX_OUTSTANDING);
  localparam logic [SET_W-1:0] SETTLE_LOAD = SET_W'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {ACTIVE, DRAIN, SWITCH, SETTLE} state_e;

  state_e                 state_q, state_d;
  logic [LOG_N_HWPES-1:0] sel_q, sel_d;
  logic [LOG_N_HWPES-1:0] next_sel_q, next_sel_d;
  logic [OUT_W-1:0]       outstanding_q, outstanding_d;
  logic                   cfg_pending_q, cfg_pending_d;
  logic [SET_W-1:0]       settle_q, settle_d;

  logic             req_in_range;
  logic             handshake;
  logic             is_active;
  logic             tcdm_fire;
  logic             rsp_fire;
  logic             cfg_fire;
  logic             sel_busy;
  logic             sel_tcdm_req;
  logic             sel_periph_gnt;
  logic             sel_periph_r_valid;
  logic [EVT_W-1:0] sel_evt;

  // With a power-of-two HWPE count every encodable index is valid.
  if (N_HWPES == (1 << LOG_N_HWPES)) begin : g_full_range
    assign req_in_range = 1'b1;
  end else begin : g_part_range
    assign req_in_range = (sel_req_i < LOG_N_HWPES'(N_HWPES));
  end

  // Per-HWPE inputs seen through the current select.
  always_comb begin
    sel_busy           = 1'b0;
    sel_tcdm_req       = 1'b0;
    sel_periph_gnt     = 1'b0;
    sel_periph_r_valid = 1'b0;
    sel_evt            = '0;
    for (int i = 0; i < N_HWPES; i++) begin
      if (sel_q == LOG_N_HWPES'(i)) begin
        sel_busy           = hwpe_busy_i[i];
        sel_tcdm_req       = hwpe_tcdm_req_i[i];
        sel_periph_gnt     = periph_gnt_i[i];
        sel_periph_r_valid = periph_r_valid_i[i];
        sel_evt            = hwpe_evt_i[i*EVT_W +: EVT_W];
      end
    end
  end

  assign is_active       = (state_q == ACTIVE);
  assign sel_req_ready_o = is_active;
  assign switching_o     = ~is_active;
  assign handshake       = sel_req_valid_i & sel_req_ready_o;
  assign sel_o           = sel_q;

  assign tcdm_req_o = is_active & sel_tcdm_req & (outstanding_q < MAX_OUT);
  assign tcdm_fire  = tcdm_req_o & tcdm_gnt_i;
  // A response with nothing in flight is spurious and must not underflow.
  assign rsp_fire   = tcdm_r_valid_i & (outstanding_q != '0);

  assign cfg_gnt_o = is_active & sel_periph_gnt;
  assign cfg_fire  = cfg_req_i & cfg_gnt_o;

  assign evt_o  = is_active ? sel_evt : '0;
  assign busy_o = sel_busy | switching_o;

  always_comb begin
    hwpe_clk_en_o   = '0;
    hwpe_tcdm_gnt_o = '0;
    periph_req_o    = '0;
    for (int i = 0; i < N_HWPES; i++) begin
      if (sel_q == LOG_N_HWPES'(i)) begin
        hwpe_clk_en_o[i]   = hwpe_en_i & (state_q != SWITCH);
        hwpe_tcdm_gnt_o[i] = tcdm_fire;
        periph_req_o[i]    = cfg_req_i & is_active;
      end
    end
  end

  always_comb begin
    outstanding_d = outstanding_q;
    if (tcdm_fire && !rsp_fire) begin
      outstanding_d = outstanding_q + OUT_W'(1);
    end else if (!tcdm_fire && rsp_fire) begin
      outstanding_d = outstanding_q - OUT_W'(1);
    end
  end

  // A new config grant wins over a response seen in the same cycle.
  always_comb begin
    cfg_pending_d = cfg_pending_q;
    if (cfg_fire) begin
      cfg_pending_d = 1'b1;
    end else if (sel_periph_r_valid) begin
      cfg_pending_d = 1'b0;
    end
  end

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    next_sel_d = next_sel_q;
    settle_d   = settle_q;
    case (state_q)
      ACTIVE: begin
        if (handshake && req_in_range && (sel_req_i != sel_q)) begin
          next_sel_d = sel_req_i;
          state_d    = DRAIN;
        end
      end
      DRAIN: begin
        if ((outstanding_q == '0) && !cfg_pending_q && !sel_busy) begin
          state_d = SWITCH;
        end
      end
      SWITCH: begin
        sel_d    = next_sel_q;
        settle_d = SETTLE_LOAD;
        state_d  = SETTLE;
      end
      SETTLE: begin
        if (settle_q == '0) begin
          state_d = ACTIVE;
        end else begin
          settle_d = settle_q - SET_W'(1);
        end
      end
      default: state_d = ACTIVE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ACTIVE;
      sel_q         <= '0;
      next_sel_q    <= '0;
      outstanding_q <= '0;
      cfg_pending_q <= 1'b0;
      settle_q      <= '0;
    end else begin
      state_q       <= state_d;
      sel_q         <= sel_d;
      next_sel_q    <= next_sel_d;
      outstanding_q <= outstanding_d;
      cfg_pending_q <= cfg_pending_d;
      settle_q      <= settle_d;
    end
  end

endmodule

// File: tb/tb_hwpe_sel_ctrl.sv
module tb_hwpe_sel_ctrl;

  localparam int N  = 4;
  localparam int L  = 2;
  localparam int NC = 8;
  localparam int MO = 4;
  localparam int SC = 2;
  localparam int EW = 2 * NC;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // main instance, N_HWPES=4
  logic              rst_n, hwpe_en_i, sel_req_valid_i;
  logic [L-1:0]      sel_req_i;
  logic              sel_req_ready_o, switching_o, busy_o;
  logic [L-1:0]      sel_o;
  logic [N-1:0]      hwpe_clk_en_o, hwpe_busy_i, hwpe_tcdm_req_i, hwpe_tcdm_gnt_o;
  logic [N*EW-1:0]   hwpe_evt_i;
  logic [EW-1:0]     evt_o;
  logic              tcdm_req_o, tcdm_gnt_i, tcdm_r_valid_i, cfg_req_i, cfg_gnt_o;
  logic [N-1:0]      periph_req_o, periph_gnt_i, periph_r_valid_i;

  hwpe_sel_ctrl #(.N_HWPES(N), .N_CORES(NC), .MAX_OUTSTANDING(MO), .SETTLE_CYCLES(SC)) dut (
    .clk(clk), .rst_n(rst_n), .hwpe_en_i(hwpe_en_i),
    .sel_req_i(sel_req_i), .sel_req_valid_i(sel_req_valid_i), .sel_req_ready_o(sel_req_ready_o),
    .sel_o(sel_o), .switching_o(switching_o), .hwpe_clk_en_o(hwpe_clk_en_o),
    .hwpe_busy_i(hwpe_busy_i), .hwpe_evt_i(hwpe_evt_i), .evt_o(evt_o), .busy_o(busy_o),
    .hwpe_tcdm_req_i(hwpe_tcdm_req_i), .hwpe_tcdm_gnt_o(hwpe_tcdm_gnt_o),
    .tcdm_req_o(tcdm_req_o), .tcdm_gnt_i(tcdm_gnt_i), .tcdm_r_valid_i(tcdm_r_valid_i),
    .cfg_req_i(cfg_req_i), .cfg_gnt_o(cfg_gnt_o),
    .periph_req_o(periph_req_o), .periph_gnt_i(periph_gnt_i), .periph_r_valid_i(periph_r_valid_i)
  );

  // second instance, N_HWPES=3, so that index 3 is out of range
  logic              t3_rst_n, t3_valid, t3_ready, t3_switching, t3_busy_o;
  logic [1:0]        t3_sel_req, t3_sel;
  logic [2:0]        t3_clk_en, t3_busy, t3_treq, t3_tgnt, t3_preq, t3_pgnt, t3_prv;
  logic [3*EW-1:0]   t3_evt_in;
  logic [EW-1:0]     t3_evt_o;
  logic              t3_tcdm_req, t3_cfg_gnt;

  hwpe_sel_ctrl #(.N_HWPES(3), .N_CORES(NC), .MAX_OUTSTANDING(MO), .SETTLE_CYCLES(SC)) dut3 (
    .clk(clk), .rst_n(t3_rst_n), .hwpe_en_i(1'b1),
    .sel_req_i(t3_sel_req), .sel_req_valid_i(t3_valid), .sel_req_ready_o(t3_ready),
    .sel_o(t3_sel), .switching_o(t3_switching), .hwpe_clk_en_o(t3_clk_en),
    .hwpe_busy_i(t3_busy), .hwpe_evt_i(t3_evt_in), .evt_o(t3_evt_o), .busy_o(t3_busy_o),
    .hwpe_tcdm_req_i(t3_treq), .hwpe_tcdm_gnt_o(t3_tgnt),
    .tcdm_req_o(t3_tcdm_req), .tcdm_gnt_i(1'b0), .tcdm_r_valid_i(1'b0),
    .cfg_req_i(1'b0), .cfg_gnt_o(t3_cfg_gnt),
    .periph_req_o(t3_preq), .periph_gnt_i(t3_pgnt), .periph_r_valid_i(t3_prv)
  );

  typedef struct packed {
    logic [L-1:0]  sel;
    logic          ready;
    logic          switching;
    logic [N-1:0]  clk_en;
    logic          tcdm_req;
    logic [N-1:0]  gnt;
    logic [N-1:0]  preq;
    logic          cfg_gnt;
    logic [EW-1:0] evt;
    logic          busy;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e, mon_a;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   gnt_seen = 0;
  int   sw_seen  = 0;
  int   clkoff_seen = 0;

  // Reference model: the switch is described as "draining" followed by a run
  // of blocked cycles, the first of which has the clocks off.
  int m_sel, m_target, m_out, m_block;
  bit m_draining, m_cfg;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_sel = 0; m_target = 0; m_out = 0; m_block = 0; m_draining = 0; m_cfg = 0;
  endtask

  task automatic step();
    exp_t         e;
    logic [N-1:0] onehot;
    bit           act, fire, rsp;
    int           n_sel, n_target, n_out, n_block;
    bit           n_draining, n_cfg;
    onehot = '0;
    onehot[m_sel] = 1'b1;
    act = !m_draining && (m_block == 0);
    e.sel       = L'(m_sel);
    e.ready     = act;
    e.switching = !act;
    e.clk_en    = (hwpe_en_i && (m_block != SC + 1)) ? onehot : '0;
    e.tcdm_req  = act && hwpe_tcdm_req_i[m_sel] && (m_out < MO);
    e.gnt       = (e.tcdm_req && tcdm_gnt_i) ? onehot : '0;
    e.preq      = (act && cfg_req_i) ? onehot : '0;
    e.cfg_gnt   = act && periph_gnt_i[m_sel];
    e.evt       = act ? hwpe_evt_i[m_sel*EW +: EW] : '0;
    e.busy      = hwpe_busy_i[m_sel] || !act;
    sb_q.push_back(e);

    n_sel = m_sel; n_target = m_target; n_block = m_block;
    n_draining = m_draining; n_cfg = m_cfg;
    fire  = e.tcdm_req && tcdm_gnt_i;
    rsp   = tcdm_r_valid_i && (m_out > 0);
    n_out = m_out + (fire ? 1 : 0) - (rsp ? 1 : 0);
    if (cfg_req_i && e.cfg_gnt) n_cfg = 1;
    else if (periph_r_valid_i[m_sel]) n_cfg = 0;
    if (act) begin
      if (sel_req_valid_i && (int'(sel_req_i) != m_sel)) begin
        n_draining = 1;
        n_target   = int'(sel_req_i);
      end
    end else if (m_draining) begin
      if (m_out == 0 && !m_cfg && !hwpe_busy_i[m_sel]) begin
        n_draining = 0;
        n_block    = SC + 1;
      end
    end else begin
      if (m_block == SC + 1) n_sel = m_target;
      n_block = m_block - 1;
    end

    @(posedge clk);
    #1;
    if (!rst_n) model_reset();
    else begin
      m_sel = n_sel; m_target = n_target; m_out = n_out; m_block = n_block;
      m_draining = n_draining; m_cfg = n_cfg;
    end
  endtask

  // Monitor: one expected record per cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      mon_a.sel = sel_o; mon_a.ready = sel_req_ready_o; mon_a.switching = switching_o;
      mon_a.clk_en = hwpe_clk_en_o; mon_a.tcdm_req = tcdm_req_o; mon_a.gnt = hwpe_tcdm_gnt_o;
      mon_a.preq = periph_req_o; mon_a.cfg_gnt = cfg_gnt_o; mon_a.evt = evt_o; mon_a.busy = busy_o;
      n_checks++;
      if (mon_a !== mon_e) begin
        n_fail++;
        $display("FAIL cycle_out t=%0t got sel=%0d rdy=%b sw=%b cke=%b treq=%b gnt=%b preq=%b cgnt=%b evt=%h busy=%b expected sel=%0d rdy=%b sw=%b cke=%b treq=%b gnt=%b preq=%b cgnt=%b evt=%h busy=%b",
                 $time, mon_a.sel, mon_a.ready, mon_a.switching, mon_a.clk_en, mon_a.tcdm_req,
                 mon_a.gnt, mon_a.preq, mon_a.cfg_gnt, mon_a.evt, mon_a.busy,
                 mon_e.sel, mon_e.ready, mon_e.switching, mon_e.clk_en, mon_e.tcdm_req,
                 mon_e.gnt, mon_e.preq, mon_e.cfg_gnt, mon_e.evt, mon_e.busy);
      end
    end
    if (hwpe_tcdm_gnt_o != '0) gnt_seen++;
    if (switching_o) sw_seen++;
    if (hwpe_en_i && hwpe_clk_en_o == '0) clkoff_seen++;
  end

  task automatic idle_inputs();
    sel_req_valid_i = 0; sel_req_i = '0; hwpe_busy_i = '0; hwpe_tcdm_req_i = '0;
    tcdm_gnt_i = 0; tcdm_r_valid_i = 0; cfg_req_i = 0; periph_gnt_i = '0; periph_r_valid_i = '0;
  endtask

  task automatic request(input int idx);
    sel_req_i = L'(idx);
    sel_req_valid_i = 1;
    step();
    sel_req_valid_i = 0;
  endtask

  initial begin
    rst_n = 0; hwpe_en_i = 1; hwpe_evt_i = '0;
    idle_inputs();
    t3_rst_n = 0; t3_valid = 0; t3_sel_req = '0; t3_busy = '0; t3_treq = '0;
    t3_evt_in = '0; t3_pgnt = '0; t3_prv = '0;
    model_reset();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1;

    // reset state
    check("rst_sel", 64'(sel_o), 64'd0);
    check("rst_clk_en", 64'(hwpe_clk_en_o), 64'b0001);
    check("rst_ready", 64'(sel_req_ready_o), 64'd1);
    check("rst_switching", 64'(switching_o), 64'd0);
    repeat (2) step();

    // clean switch 0 -> 2
    sw_seen = 0; clkoff_seen = 0;
    hwpe_evt_i = {$urandom, $urandom};
    request(2);
    repeat (6) step();
    check("switch_latency", 64'(sw_seen), 64'(2 + SC));
    check("switch_clk_off", 64'(clkoff_seen), 64'd1);
    check("switch_sel", 64'(sel_o), 64'd2);
    check("switch_clk_en", 64'(hwpe_clk_en_o), 64'b0100);

    // three granted requests, then switch toward 1 must wait for responses
    hwpe_tcdm_req_i = 4'b0100; tcdm_gnt_i = 1;
    repeat (3) step();
    tcdm_gnt_i = 0;
    request(1);
    repeat (4) step();
    check("drain_hold", 64'(switching_o), 64'd1);
    for (int i = 0; i < 3; i++) begin
      tcdm_r_valid_i = 1; step();
      tcdm_r_valid_i = 0; step();
    end
    hwpe_tcdm_req_i = '0;
    repeat (5) step();
    check("drain_done_sel", 64'(sel_o), 64'd1);

    // outstanding saturation on HWPE 1
    gnt_seen = 0;
    hwpe_tcdm_req_i = 4'b0010; tcdm_gnt_i = 1;
    repeat (8) step();
    check("sat_grants", 64'(gnt_seen), 64'(MO));
    tcdm_r_valid_i = 1; step();
    tcdm_r_valid_i = 0; repeat (3) step();
    check("sat_reopen", 64'(gnt_seen), 64'(MO + 1));
    tcdm_r_valid_i = 1; repeat (3) step();
    tcdm_r_valid_i = 0; repeat (3) step();
    hwpe_tcdm_req_i = '0; tcdm_gnt_i = 0;
    tcdm_r_valid_i = 1; repeat (4) step();
    tcdm_r_valid_i = 0;

    // busy holds the drain, config is blocked meanwhile
    hwpe_busy_i = 4'b0010;
    request(0);
    cfg_req_i = 1; periph_gnt_i = '1;
    repeat (10) step();
    check("busy_hold", 64'(sel_o), 64'd1);
    cfg_req_i = 0; periph_gnt_i = '0; hwpe_busy_i = '0;
    repeat (6) step();
    check("busy_release_sel", 64'(sel_o), 64'd0);

    // reset while settling toward 3
    request(3);
    repeat (2) step();
    check("in_settle", 64'(switching_o), 64'd1);
    rst_n = 0; step();
    rst_n = 1;
    check("mid_rst_sel", 64'(sel_o), 64'd0);
    check("mid_rst_switching", 64'(switching_o), 64'd0);
    repeat (3) step();

    // randomized traffic
    for (int c = 0; c < 2000; c++) begin
      rst_n            = ($urandom_range(0, 299) != 0);
      hwpe_en_i        = ($urandom_range(0, 15) != 0);
      sel_req_valid_i  = ($urandom_range(0, 7) == 0);
      sel_req_i        = L'($urandom_range(0, N - 1));
      hwpe_busy_i      = N'($urandom) & N'($urandom) & N'($urandom);
      hwpe_evt_i       = {$urandom, $urandom};
      hwpe_tcdm_req_i  = N'($urandom);
      tcdm_gnt_i       = $urandom_range(0, 1) != 0;
      tcdm_r_valid_i   = ($urandom_range(0, 2) == 0);
      cfg_req_i        = $urandom_range(0, 1) != 0;
      periph_gnt_i     = N'($urandom);
      periph_r_valid_i = N'($urandom) & N'($urandom);
      step();
    end
    rst_n = 1; hwpe_en_i = 1; idle_inputs();
    repeat (2) step();

    // N_HWPES=3 instance: index 3 accepted and ignored, index 2 switches
    @(posedge clk); #1;
    t3_rst_n = 1;
    t3_sel_req = 2'd3; t3_valid = 1;
    check("oor_ready", 64'(t3_ready), 64'd1);
    @(posedge clk); #1;
    t3_valid = 0;
    check("oor_switching", 64'(t3_switching), 64'd0);
    check("oor_sel", 64'(t3_sel), 64'd0);
    t3_sel_req = 2'd2; t3_valid = 1;
    @(posedge clk); #1;
    t3_valid = 0;
    check("n3_switch_start", 64'(t3_switching), 64'd1);
    repeat (2 + SC) begin @(posedge clk); #1; end
    check("n3_switch_sel", 64'(t3_sel), 64'd2);
    check("n3_switch_done", 64'(t3_switching), 64'd0);

    repeat (2) @(negedge clk);
    check("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
